// File: rtl/hex_mem_pkg.sv
// Shared types and default sizes for the unified-memory port arbiter.
package hex_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned BE_W       = DEF_DATA_W / 8;
    localparam logic [BE_W-1:0] BE_ALL = '1;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module mem_arb_starve_ctr
    import hex_mem_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority over increment; increment stops at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            at_limit <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            at_limit <= (cnt_d == CNT_W'(LIMIT));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store access to one variable-latency memory.
module mem_port_arbiter
    import hex_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned MBE_W = DATA_W / 8;

    arb_state_e state_q;
    arb_state_e state_d;
    logic       take_if;
    logic       take_dm;
    logic       starve_hit;
    logic       starve_clr;
    logic       starve_inc;

    // Data wins a collision unless fetch has already been passed over STARVE_MAX times.
    always_comb begin
        state_d = state_q;
        take_if = 1'b0;
        take_dm = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req && !(if_req && starve_hit)) begin
                    state_d = GNT_DM;
                    take_dm = 1'b1;
                end else if (if_req) begin
                    state_d = GNT_IF;
                    take_if = 1'b1;
                end
            end
            GNT_IF: if (mem_ready) state_d = IDLE;
            GNT_DM: if (mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory command is captured on grant entry and held until acknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            mem_req <= (state_d != IDLE);
            busy    <= (state_d != IDLE);
            if (take_if) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= {MBE_W{1'b1}};
            end else if (take_dm) begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_be    <= dm_be;
            end
        end
    end

    assign starve_clr = take_if || ((state_q == IDLE) && !if_req);
    assign starve_inc = take_dm && if_req;

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .clr      (starve_clr),
        .inc      (starve_inc),
        .at_limit (starve_hit)
    );

    // Completion and read data are combinational so the stage unfreezes in the ack cycle.
    assign if_done  = (state_q == GNT_IF) && mem_ready;
    assign dm_done  = (state_q == GNT_DM) && mem_ready;
    assign if_rdata = if_done ? mem_rdata : '0;
    assign dm_rdata = (dm_done && !dm_we) ? mem_rdata : '0;
    assign if_stall = if_req && !if_done;
    assign dm_stall = dm_req && !dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int chk  = 0;
    int pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .dm_stall  (dm_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got=%0h want=0", mem_req); else pass++;
        chk++; if (if_done !== 1'b0) $display("FAIL rst_if_done got=%0h want=0", if_done); else pass++;
        chk++; if (if_stall !== 1'b1) $display("FAIL rst_if_stall got=%0h want=1", if_stall); else pass++;
        chk++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0h want=0", busy); else pass++;
        chk++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got=%0h want=0", mem_addr); else pass++;
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk++; if (mem_req !== 1'b1) $display("FAIL rel_mem_req got=%0h want=1", mem_req); else pass++;
        chk++; if (mem_addr !== 32'h40) $display("FAIL rel_mem_addr got=%0h want=40", mem_addr); else pass++;
        tick();
        if_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h00500113; mem_ready = 1'b1;
        @(negedge clk);
        chk++; if (if_done !== 1'b0) $display("FAIL fetch_n_done got=%0h want=0", if_done); else pass++;
        chk++; if (if_stall !== 1'b1) $display("FAIL fetch_n_stall got=%0h want=1", if_stall); else pass++;
        tick();
        @(negedge clk);
        chk++; if (if_done !== 1'b1) $display("FAIL fetch_done got=%0h want=1", if_done); else pass++;
        chk++; if (if_rdata !== 32'h00500113) $display("FAIL fetch_rdata got=%0h want=00500113", if_rdata); else pass++;
        chk++; if (mem_be !== 4'hF) $display("FAIL fetch_be got=%0h want=f", mem_be); else pass++;
        chk++; if (mem_we !== 1'b0) $display("FAIL fetch_we got=%0h want=0", mem_we); else pass++;
        chk++; if (mem_addr !== 32'h10) $display("FAIL fetch_addr got=%0h want=10", mem_addr); else pass++;
        chk++; if (if_stall !== 1'b0) $display("FAIL fetch_stall got=%0h want=0", if_stall); else pass++;
        chk++; if (dm_done !== 1'b0) $display("FAIL fetch_dm_done got=%0h want=0", dm_done); else pass++;
        tick();
        if_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk++; if (busy !== 1'b0) $display("FAIL fetch_busy_n2 got=%0h want=0", busy); else pass++;
        chk++; if (if_rdata !== 32'h0) $display("FAIL fetch_rdata_n2 got=%0h want=0", if_rdata); else pass++;
    endtask

    task automatic test_store_wait();
        int pulses = 0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd100; dm_wdata = 32'd7; dm_be = 4'hF;
        mem_ready = 1'b0; mem_rdata = 32'hDEADBEEF;
        for (int g = 1; g <= 4; g++) begin
            tick();
            if (g == 4) mem_ready = 1'b1;
            @(negedge clk);
            chk++; if (mem_addr !== 32'd100) $display("FAIL st_addr g=%0d got=%0d want=100", g, mem_addr); else pass++;
            chk++; if (mem_wdata !== 32'd7) $display("FAIL st_wdata g=%0d got=%0d want=7", g, mem_wdata); else pass++;
            chk++; if (mem_we !== 1'b1) $display("FAIL st_we g=%0d got=%0h want=1", g, mem_we); else pass++;
            chk++; if (dm_done !== (g == 4)) $display("FAIL st_done g=%0d got=%0h want=%0h", g, dm_done, (g == 4)); else pass++;
            chk++; if (dm_rdata !== 32'h0) $display("FAIL st_rdata g=%0d got=%0h want=0", g, dm_rdata); else pass++;
            if (dm_done === 1'b1) pulses++;
        end
        tick();
        dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk++; if (pulses != 1) $display("FAIL st_pulses got=%0d want=1", pulses); else pass++;
        chk++; if (busy !== 1'b0) $display("FAIL st_busy got=%0h want=0", busy); else pass++;
    endtask

    task automatic test_collision();
        logic exp_dm;
        if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        dm_be = 4'h3; mem_ready = 1'b1; mem_rdata = 32'h12345678;
        for (int k = 1; k <= 6; k++) begin
            exp_dm = (k != 5);
            tick();
            @(negedge clk);
            chk++; if (mem_addr !== (exp_dm ? 32'h300 : 32'h200)) $display("FAIL col_addr k=%0d got=%0h want=%0h", k, mem_addr, (exp_dm ? 32'h300 : 32'h200)); else pass++;
            chk++; if (dm_done !== exp_dm) $display("FAIL col_dm_done k=%0d got=%0h want=%0h", k, dm_done, exp_dm); else pass++;
            chk++; if (if_done !== !exp_dm) $display("FAIL col_if_done k=%0d got=%0h want=%0h", k, if_done, !exp_dm); else pass++;
            chk++; if (dm_rdata !== (exp_dm ? 32'h12345678 : 32'h0)) $display("FAIL col_dm_rdata k=%0d got=%0h", k, dm_rdata); else pass++;
            chk++; if (mem_be !== (exp_dm ? 4'h3 : 4'hF)) $display("FAIL col_be k=%0d got=%0h want=%0h", k, mem_be, (exp_dm ? 4'h3 : 4'hF)); else pass++;
            tick();
            if (k == 6) begin
                if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
            end
            @(negedge clk);
            chk++; if (busy !== 1'b0) $display("FAIL col_idle k=%0d got=%0h want=0", k, busy); else pass++;
        end
    endtask

    task automatic test_reset_mid();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd96; mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk++; if (mem_req !== 1'b0) $display("FAIL rmid_mem_req got=%0h want=0", mem_req); else pass++;
        chk++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%0h want=0", busy); else pass++;
        chk++; if (dm_done !== 1'b0) $display("FAIL rmid_done got=%0h want=0", dm_done); else pass++;
        tick();
        @(negedge clk);
        chk++; if (dm_stall !== 1'b1) $display("FAIL rmid_stall got=%0h want=1", dm_stall); else pass++;
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk++; if (mem_req !== 1'b1) $display("FAIL rmid_regnt got=%0h want=1", mem_req); else pass++;
        chk++; if (mem_addr !== 32'd96) $display("FAIL rmid_addr got=%0d want=96", mem_addr); else pass++;
        chk++; if (dm_done !== 1'b0) $display("FAIL rmid_wait_done got=%0h want=0", dm_done); else pass++;
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        chk++; if (dm_done !== 1'b1) $display("FAIL rmid_done2 got=%0h want=1", dm_done); else pass++;
        tick();
        dm_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_spurious_ack();
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk++; if (if_done !== 1'b0) $display("FAIL spur_if_done got=%0h want=0", if_done); else pass++;
        chk++; if (dm_done !== 1'b0) $display("FAIL spur_dm_done got=%0h want=0", dm_done); else pass++;
        chk++; if (if_rdata !== 32'h0) $display("FAIL spur_if_rdata got=%0h want=0", if_rdata); else pass++;
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk++; if (busy !== 1'b0) $display("FAIL spur_busy got=%0h want=0", busy); else pass++;
        chk++; if (mem_req !== 1'b0) $display("FAIL spur_mem_req got=%0h want=0", mem_req); else pass++;
        // A collision now must still favour data, showing the counter sits below its limit.
        if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b1; dm_addr = 32'h600; mem_ready = 1'b1;
        tick();
        @(negedge clk);
        chk++; if (mem_addr !== 32'h600) $display("FAIL spur_cnt_addr got=%0h want=600", mem_addr); else pass++;
        chk++; if (dm_done !== 1'b1) $display("FAIL spur_cnt_done got=%0h want=1", dm_done); else pass++;
        tick();
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_collision();
        test_reset_mid();
        test_spurious_ack();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
